// File: rtl/run_monitor_if.sv
// run_monitor_if: valid/ready stream carrying dumped data-memory words.
//   dump_valid : dump_data/dump_idx hold a word (producer -> consumer)
//   dump_ready : consumer takes the word on this edge (consumer -> producer)
//   dump_data  : dumped 32-bit word
//   dump_idx   : offset of dump_data from the dump base word index
interface run_monitor_if;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_data;
  logic [7:0]  dump_idx;

  modport master (
    output dump_valid,
    output dump_data,
    output dump_idx,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_data,
    input  dump_idx,
    output dump_ready
  );
endinterface

// File: rtl/run_monitor.sv
// run_monitor: snoops CPU data-memory traffic, counts run and stall cycles,
// detects the terminating store to HALT_ADDR, then freezes the CPU and
// streams DUMP_LEN words starting at DUMP_BASE out of dmem.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   daddr        : CPU data byte address
//   ddataout     : CPU store data
//   we           : CPU store strobe
//   stall        : CPU pipeline stall indicator
//   mem_a        : word index to the dmem read port
//   mem_rd       : combinational dmem read data for mem_a
//   halt         : freeze request (DUMP and DONE)
//   dump         : valid/ready word stream (run_monitor_if.master)
//   done         : dump complete or watchdog expired
//   timeout      : run ended by the watchdog
//   result       : data of the halt store
//   cycle_count  : run cycles (halt edge excluded)
//   stall_count  : stalled run cycles (halt edge excluded)
//
// Optional feature: define RUN_WATCHDOG_EN to end a run that reaches
// WATCHDOG_MAX cycles without a halt store.
module run_monitor #(
  parameter logic [31:0] HALT_ADDR    = 32'd100,
  parameter logic [15:0] DUMP_BASE    = 16'd200,
  parameter int          DUMP_LEN     = 100,
  parameter int          WATCHDOG_MAX = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          daddr,
  input  logic [31:0]          ddataout,
  input  logic                 we,
  input  logic                 stall,
  output logic [15:0]          mem_a,
  input  logic [31:0]          mem_rd,
  output logic                 halt,
  run_monitor_if.master        dump,
  output logic                 done,
  output logic                 timeout,
  output logic [31:0]          result,
  output logic [31:0]          cycle_count,
  output logic [31:0]          stall_count
);

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] DUMP = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [8:0]  dump_len_w = 9'(DUMP_LEN);
  localparam logic [31:0] wd_last    = 32'(WATCHDOG_MAX - 1);
  localparam logic [31:0] wd_top     = 32'(WATCHDOG_MAX);

`ifdef RUN_WATCHDOG_EN
  localparam bit wd_en = 1'b1;
`else
  // Watchdog compare is constant-false, so timeout stays 0 and RUN never ends
  // except by a halt store.
  localparam bit wd_en = 1'b0;
`endif

  logic [1:0]  state;
  logic [8:0]  ptr;
  logic        dump_valid_q;
  logic [31:0] dump_data_q;
  logic [7:0]  dump_idx_q;
  logic        timeout_q;

  logic halt_store;
  logic fetch;
  logic last_taken;

  assign halt_store = we && (daddr == HALT_ADDR);
  // A new word may be fetched whenever the output slot is empty or is being
  // consumed on this same edge, which gives one word per cycle under ready.
  assign fetch      = (ptr < dump_len_w) && (!dump_valid_q || dump.dump_ready);
  assign last_taken = dump_valid_q && dump.dump_ready && (ptr == dump_len_w);

  // Index is truncated to 16 bits by the sized sum.
  assign mem_a = (state == DUMP) ? 16'(DUMP_BASE + {7'd0, ptr}) : DUMP_BASE;

  assign halt    = (state == DUMP) || (state == DONE);
  assign done    = (state == DONE);
  assign timeout = timeout_q;

  assign dump.dump_valid = dump_valid_q;
  assign dump.dump_data  = dump_data_q;
  assign dump.dump_idx   = dump_idx_q;

  // NOTE: every register here is updated with non-blocking assignments so all
  // reads in this block see pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      ptr          <= '0;
      dump_valid_q <= 1'b0;
      dump_data_q  <= '0;
      dump_idx_q   <= '0;
      timeout_q    <= 1'b0;
      result       <= '0;
      cycle_count  <= '0;
      stall_count  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (halt_store) begin
            // The halt edge itself is not a counted run cycle.
            result <= ddataout;
            state  <= DUMP;
          end else if (wd_en && (cycle_count == wd_last)) begin
            cycle_count <= wd_top;
            stall_count <= stall_count + {31'd0, stall};
            timeout_q   <= 1'b1;
            state       <= DONE;
          end else begin
            cycle_count <= cycle_count + 32'd1;
            stall_count <= stall_count + {31'd0, stall};
          end
        end

        DUMP: begin
          if (fetch) begin
            dump_data_q  <= mem_rd;
            dump_idx_q   <= ptr[7:0];
            dump_valid_q <= 1'b1;
            ptr          <= ptr + 9'd1;
          end else if (last_taken) begin
            dump_valid_q <= 1'b0;
            state        <= DONE;
          end
        end

        default: begin
          // DONE: frozen until reset.
        end
      endcase
    end
  end

endmodule
